alu_exec_pipe: RTL and testbench
================================

// Module: alu_exec_pipe
// PURPOSE
//  Parametrised execute stage between decode and memory: one input register with a
//  valid/ready handshake, immediate select by opcode, single-cycle ALU, and an
//  iterative shift-add multiplier. Opaque sideband (dest reg, we, pc, ROB tail,
//  ld/st bits) rides alongside each op unchanged. Accepts back-pressure and flush.
// PARAMETERS
//  DATA_W  16  operand/result width (>=8)
//  IMM_W   9   immediate width (<DATA_W); zero-extended to DATA_W
//  SB_W    40  sideband width carried with each op
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-high
//  flush        in   1        sync kill of held/in-flight op
//  in_valid     in   1        decode presents an op
//  in_ready     out  1        stage can accept this cycle
//  regA         in   DATA_W   operand A
//  regB         in   DATA_W   operand B
//  cop          in   4        opcode
//  inmediate    in   IMM_W    immediate
//  sb_in        in   SB_W     sideband
//  out_valid    out  1        result valid
//  out_ready    in   1        downstream takes result
//  alu_result   out  DATA_W   result
//  OVF          out  1        overflow
//  illegal      out  1        unsupported opcode
//  sb_out       out  SB_W     sideband of the op on alu_result
// BEHAVIOUR
//  Opcodes: 0000 ADD, 0001 SUB, 0011 MOV(=imm), 0100 AND, 0101 OR, 0110 LD/0111 ST
//   (A+imm), 1000 MUL. B operand = zext(imm) for 0011/0110/0111, else regB.
//  Others: result 0, OVF 0, illegal 1 (op still completes normally).
//  ADD/SUB/LD/ST: OVF = signed two's-complement overflow; result wraps mod 2^DATA_W.
//  FSM states: EMPTY, FULL, MUL_BUSY. Reset -> EMPTY; out_valid=0, alu_result=0,
//   OVF=0, illegal=0, sb_out=0, mul counter=0.
//  in_ready = !flush && (EMPTY || (FULL && out_ready)).
//  Accept (in_valid&&in_ready): non-MUL -> FULL, result registered; out_valid next
//   cycle (latency 1). MUL -> MUL_BUSY, counter=DATA_W.
//  MUL_BUSY: one multiplier bit per cycle; after DATA_W cycles -> FULL; out_valid
//   DATA_W+1 cycles after acceptance. Result = low DATA_W bits of unsigned product;
//   OVF = 1 if any high DATA_W bits nonzero. in_ready=0 throughout.
//  FULL: outputs held stable while out_valid && !out_ready. Hand-off with
//   out_ready and new accept in same cycle -> stays FULL with new op (full rate).
//   out_ready without accept -> EMPTY, out_valid=0.
//  flush (highest priority): next state EMPTY, out_valid=0, in-flight MUL aborted;
//   in_ready=0 that cycle so no op is taken. Data outputs may hold stale values.
//  reset mid-MUL: asynchronously to EMPTY, all outputs to reset values.
//  out_valid never asserted in EMPTY or MUL_BUSY; sb_out always matches alu_result.
// CONFIGURATION
//  ALU_EXEC_MUL_EN defined: MUL (1000) as above, MUL_BUSY state and counter present.
//  Not defined: 1000 is illegal (result 0, illegal=1, latency 1); no MUL_BUSY state.
// TESTING
//  ADD 0x7FFF+0x0001, out_ready=1 -> next cycle out_valid, result 0x8000, OVF=1
//  LD regA=0x0100 imm=0x1FF, regB=0xFFFF -> result 0x02FF, OVF=0 (imm used)
//  3 back-to-back SUB ops, out_ready=0 for 4 cycles -> 1st held stable, in_ready=0
//   after 1st accept; release -> 3 results in order, 1/cycle, sb_out matching
//  MUL 0x0100*0x0200 (MUL_EN) -> out_valid 17 cycles after accept, result 0, OVF=1;
//   without MUL_EN -> 1 cycle, result 0, illegal=1
//  flush at cycle 5 of a MUL with in_valid=1 -> in_ready=0, next cycle EMPTY,
//   no out_valid; subsequent ADD completes normally
//  reset pulse mid-FULL, asynchronous to clk -> out_valid=0, alu_result=0 immediately

Source files
------------

// File: rtl/alu_exec_pipe.sv
// Execute stage: one result register behind a valid/ready handshake, immediate select,
// single-cycle ALU; define ALU_EXEC_MUL_EN to add the iterative shift-add multiplier.
//
// state    | meaning
// EMPTY    | nothing held, stage can accept
// FULL     | result held on outputs, out_valid high
// MUL_BUSY | shift-add multiply running, input stalled
module alu_exec_pipe #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 9,
    parameter int SB_W   = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] regA,
    input  logic [DATA_W-1:0] regB,
    input  logic [3:0]        cop,
    input  logic [IMM_W-1:0]  inmediate,
    input  logic [SB_W-1:0]   sb_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic              OVF,
    output logic              illegal,
    output logic [SB_W-1:0]   sb_out
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam int ZEXT_W = DATA_W - IMM_W;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MOV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_LD  = 4'b0110;
    localparam logic [3:0] OP_ST  = 4'b0111;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              illegal_q, illegal_d;
    logic [SB_W-1:0]   sb_q, sb_d;

    logic              accept;
    logic [DATA_W-1:0] op_b, sum, diff, alu_res;
    logic              alu_ovf, alu_ill;

`ifdef ALU_EXEC_MUL_EN
    localparam logic [1:0] MUL_BUSY = 2'd2;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] MUL_CNT_LAST = CNT_W'(1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [SB_W-1:0]     mul_sb_q, mul_sb_d;
    logic                is_mul;
`endif

    always_comb begin : alu
        op_b = regB;
        if (cop == OP_MOV || cop == OP_LD || cop == OP_ST) begin
            op_b = {{ZEXT_W{1'b0}}, inmediate};
        end
        sum     = regA + op_b;
        diff    = regA - op_b;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        is_mul  = 1'b0;
`endif
        case (cop)
            OP_ADD, OP_LD, OP_ST: begin
                alu_res = sum;
                alu_ovf = (regA[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != regA[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (regA[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != regA[DATA_W-1]);
            end
            OP_MOV: alu_res = op_b;
            OP_AND: alu_res = regA & op_b;
            OP_OR:  alu_res = regA | op_b;
`ifdef ALU_EXEC_MUL_EN
            OP_MUL: is_mul = 1'b1;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    assign in_ready = !flush && (state_q == EMPTY || (state_q == FULL && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin : fsm
        state_d   = state_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        sb_d      = sb_q;
`ifdef ALU_EXEC_MUL_EN
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        mplier_d  = mplier_q;
        mul_sb_d  = mul_sb_q;
`endif
        if (flush) begin
            state_d = EMPTY;
`ifdef ALU_EXEC_MUL_EN
            cnt_d   = '0;
`endif
        end else if (accept) begin
`ifdef ALU_EXEC_MUL_EN
            if (is_mul) begin
                state_d  = MUL_BUSY;
                cnt_d    = MUL_CNT_INIT;
                mcand_d  = {{DATA_W{1'b0}}, regA};
                mplier_d = regB;
                prod_d   = '0;
                mul_sb_d = sb_in;
            end else
`endif
            begin
                state_d   = FULL;
                result_d  = alu_res;
                ovf_d     = alu_ovf;
                illegal_d = alu_ill;
                sb_d      = sb_in;
            end
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
`ifdef ALU_EXEC_MUL_EN
        else if (state_q == MUL_BUSY) begin
            prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - MUL_CNT_LAST;
            // Result and sideband land together so sb_out never leads alu_result.
            if (cnt_q == MUL_CNT_LAST) begin
                state_d   = FULL;
                result_d  = prod_d[DATA_W-1:0];
                ovf_d     = |prod_d[2*DATA_W-1:DATA_W];
                illegal_d = 1'b0;
                sb_d      = mul_sb_q;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            sb_q      <= '0;
`ifdef ALU_EXEC_MUL_EN
            cnt_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            mul_sb_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            sb_q      <= sb_d;
`ifdef ALU_EXEC_MUL_EN
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            mplier_q  <= mplier_d;
            mul_sb_q  <= mul_sb_d;
`endif
        end
    end

    assign out_valid  = (state_q == FULL);
    assign alu_result = result_q;
    assign OVF        = ovf_q;
    assign illegal    = illegal_q;
    assign sb_out     = sb_q;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Bench for alu_exec_pipe: slot/countdown reference model checked every cycle plus
// hand-computed directed expectations; honours ALU_EXEC_MUL_EN like the design.
module tb_alu_exec_pipe;
`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] regA, regB, alu_result;
    logic [3:0]  cop;
    logic [8:0]  inmediate;
    logic [39:0] sb_in, sb_out;
    logic        OVF, illegal;

    int n_vec = 0;
    int n_err = 0;
    int tag   = 1;

    alu_exec_pipe dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .regA(regA), .regB(regB), .cop(cop), .inmediate(inmediate), .sb_in(sb_in),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .OVF(OVF), .illegal(illegal), .sb_out(sb_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one op: {result, ovf, illegal}, via wide signed/unsigned math.
    function automatic logic [17:0] golden(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [8:0] imm);
        logic [15:0] bb, r;
        logic        o, il;
        int          s;
        longint      p;
        bb = (op == 4'h3 || op == 4'h6 || op == 4'h7) ? 16'(imm) : b;
        r = '0; o = 1'b0; il = 1'b0; s = 0; p = 0;
        case (op)
            4'h0, 4'h6, 4'h7: begin
                s = int'($signed(a)) + int'($signed(bb));
                r = 16'(s);
                o = (s > 32767) || (s < -32768);
            end
            4'h1: begin
                s = int'($signed(a)) - int'($signed(bb));
                r = 16'(s);
                o = (s > 32767) || (s < -32768);
            end
            4'h3: r = bb;
            4'h4: r = a & bb;
            4'h5: r = a | bb;
            4'h8: begin
                if (MUL_EN) begin
                    p = longint'(a) * longint'(bb);
                    r = p[15:0];
                    o = (p >> 16) != 0;
                end else begin
                    il = 1'b1;
                end
            end
            default: il = 1'b1;
        endcase
        return {r, o, il};
    endfunction

    // Model: one output slot plus a countdown while a multiply is in flight.
    logic        m_valid;
    int          m_busy;
    logic [57:0] m_out, p_out;

    function automatic logic model_ready();
        return !flush && (m_busy == 0) && (!m_valid || out_ready);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_busy  <= 0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_busy  <= 0;
        end else if (m_busy != 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_valid <= 1'b1;
                m_out   <= p_out;
            end
        end else if (in_valid && model_ready()) begin
            if (MUL_EN && cop == 4'h8) begin
                m_valid <= 1'b0;
                m_busy  <= 16;
                p_out   <= {golden(cop, regA, regB, inmediate), sb_in};
            end else begin
                m_valid <= 1'b1;
                m_out   <= {golden(cop, regA, regB, inmediate), sb_in};
            end
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_out_valid", out_valid, m_valid);
            chk("model_in_ready", in_ready, model_ready());
            if (m_valid) begin
                chk("model_result", alu_result, m_out[57:42]);
                chk("model_ovf", OVF, m_out[41]);
                chk("model_illegal", illegal, m_out[40]);
                chk("model_sb", sb_out, m_out[39:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op and hold it until the stage takes it; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [8:0] imm);
        int k;
        k = 0;
        cop = op; regA = a; regB = b; inmediate = imm;
        sb_in = {8'h5A, 32'(tag)};
        tag++;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_err++;
            $display("FAIL issue_timeout: in_ready stuck 0 for op %0h", op);
        end
        tick();
        in_valid = 1'b0;
    endtask

    logic [15:0] ta [8];
    logic [39:0] sb_first;
    int          k;

    initial begin
        ta = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234, 16'h00FF, 16'h0003, 16'hA5A5};
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        regA = '0; regB = '0; cop = '0; inmediate = '0; sb_in = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", alu_result, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_sb", sb_out, 0);
        tick();
        reset = 1'b0;

        issue(4'h0, 16'h7FFF, 16'h0001, 9'h000);
        @(negedge clk);
        chk("add_valid", out_valid, 1);
        chk("add_result", alu_result, 16'h8000);
        chk("add_ovf", OVF, 1);
        tick();

        issue(4'h6, 16'h0100, 16'hFFFF, 9'h1FF);
        @(negedge clk);
        chk("ld_result", alu_result, 16'h02FF);
        chk("ld_ovf", OVF, 0);
        tick();

        issue(4'h2, 16'h1111, 16'h2222, 9'h000);
        @(negedge clk);
        chk("illegal_flag", illegal, 1);
        chk("illegal_result", alu_result, 0);
        tick();

        // Back-pressure: first SUB held, next two wait, then drain at full rate.
        out_ready = 1'b0;
        issue(4'h1, 16'h0010, 16'h0003, 9'h000);
        sb_first = sb_in;
        cop = 4'h1; regA = 16'h8000; regB = 16'h0001; sb_in = 40'hAA_0000_0002; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", alu_result, 16'h000D);
            chk("hold_sb", sb_out, sb_first);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel1_result", alu_result, 16'h000D);
        tick();
        regA = 16'h0005; regB = 16'h0007; sb_in = 40'hAA_0000_0003;
        @(negedge clk);
        chk("rel2_result", alu_result, 16'h7FFF);
        chk("rel2_ovf", OVF, 1);
        chk("rel2_sb", sb_out, 40'hAA_0000_0002);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel3_result", alu_result, 16'hFFFE);
        chk("rel3_sb", sb_out, 40'hAA_0000_0003);
        tick();
        @(negedge clk);
        chk("drained", out_valid, 0);
        tick();

        issue(4'h8, 16'h0100, 16'h0200, 9'h000);
        k = 1;
        @(negedge clk);
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("mul_latency", k, MUL_EN ? 17 : 1);
        chk("mul_result", alu_result, 0);
        chk("mul_ovf", OVF, MUL_EN ? 1 : 0);
        chk("mul_illegal", illegal, MUL_EN ? 0 : 1);
        tick();

        // Flush a held result while the next op is offered.
        out_ready = 1'b0;
        issue(4'h5, 16'h00F0, 16'h000F, 9'h000);
        cop = 4'h0; regA = 16'h0005; regB = 16'h0006; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_add", alu_result, 16'h000B);
        tick();

`ifdef ALU_EXEC_MUL_EN
        issue(4'h8, 16'h1234, 16'h0011, 9'h000);
        cop = 4'h0; regA = 16'h0020; regB = 16'h0022; in_valid = 1'b1;
        repeat (4) tick();
        flush = 1'b1;
        @(negedge clk);
        chk("mulflush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("mulflush_out_valid", out_valid, 0);
        chk("mulflush_empty_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mulflush_add", alu_result, 16'h0042);
        tick();
        issue(4'h8, 16'h0003, 16'h0005, 9'h000);
        repeat (16) tick();
        @(negedge clk);
        chk("mul_small", alu_result, 16'h000F);
        chk("mul_small_ovf", OVF, 0);
        tick();
`endif

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        issue(4'h0, 16'h0001, 16'h0002, 9'h000);
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_result", alu_result, 0);
        chk("arst_sb", sb_out, 0);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            issue(i[3:0], ta[i % 8], ta[(i + 3) % 8], 9'(i * 37));
            if (i % 3 == 2) begin
                out_ready = 1'b0;
                repeat (2) tick();
                out_ready = 1'b1;
            end
        end
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
